rr_addr_arbiter: RTL and testbench
==================================

Name: rr_addr_arbiter

Overview:
- Round-robin arbiter sharing one addressed resource among 15 requesters.
- Grants the resource to one requester at a time and holds the grant until that requester releases it.
- Drives a one-hot grant vector and its 4-bit encoded address, so downstream logic can index the shared resource directly.
- Sits between the 15 request sources and the address-decoded datapath it sequences.

Parameters:
- HOLD_MAX, 255: maximum grant length in cycles, used only with the optional feature; legal range 1..255.
- PTR_INIT, 14: index treated as "last granted" after reset, so index 0 has top priority first; legal range 0..14.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ReqIn  input  15  request lines; bit k high means requester k wants the resource. Level-sensitive; any number of bits may be high.
- Release  input  1  the current owner is done; sampled only in state GRANT.
- GntOut  output  15  registered one-hot grant; all zero when there is no owner.
- GntAddr  output  4  registered encoded address of the owner. Bit 14 maps to 0; bit k maps to k+1 for k = 0..13. Value is 0 when there is no owner.
- GntValid  output  1  high while GntOut is nonzero.
- Busy  output  1  high in states GRANT and GAP.

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; GntOut = 0; GntAddr = 0; GntValid = 0; Busy = 0; pointer = PTR_INIT. Outputs clear immediately, without waiting for a clock edge. Reset asserted mid-grant drops the grant immediately.
- State IDLE:
  - If ReqIn is nonzero at a rising edge, go to GRANT.
  - The winner is the first set bit when searching in index order, starting at pointer+1 and wrapping from 14 to 0.
  - GntOut, GntAddr, GntValid and Busy are registered on that same edge. Latency is one cycle from request to grant.
  - If ReqIn is zero, stay in IDLE.
- State GRANT:
  - GntOut and GntAddr are held stable.
  - Exit when Release = 1, or when ReqIn[owner] = 0 (the requester abandoned its request).
  - On exit: pointer = owner index; clear all outputs except Busy; go to GAP.
  - Changes on other ReqIn bits are ignored in this state (no preemption).
- State GAP:
  - Lasts exactly one dead cycle, with GntValid = 0 and Busy = 1; then go to IDLE.
  - This guarantees at least one idle cycle between owners, including when Release arrives together with pending requests.
  - Back-to-back ownership therefore costs 3 cycles per owner at minimum: grant, release, gap.
- Release while in IDLE or GAP is ignored.
- Single requester: it may be re-granted after the gap, because the wrap-around search includes the pointer index itself last.
- The pointer updates only when a grant ends, never on arbitration.
- GntAddr is always the encoding of GntOut; no other values are produced.
- Only valid ReqIn patterns exist: any of the 2^15 combinations is legal. GntOut never has more than one bit set.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each cycle spent in GRANT.
  - When the counter reaches HOLD_MAX with no Release, the arbiter forces the GRANT exit exactly as if Release had been asserted: pointer update, then GAP.
  - Extra output TimeoutPulse, 1 bit, goes high for one cycle on the forced exit.
  - The counter and TimeoutPulse reset to 0.
- Not defined:
  - No counter and no TimeoutPulse port.
  - A grant lasts until Release or until the owner drops its request, with no limit.

Test Plan:
- Reset then ReqIn = 15'h0001 -> one cycle later GntOut = 15'h0001, GntAddr = 1, GntValid = 1. Assert rst_n = 0 mid-grant -> all outputs become 0 without a clock edge.
- ReqIn = 15'h4001 held, Release pulsed each grant -> grant sequence bit0 (GntAddr 1), bit14 (GntAddr 0), bit0, with one GAP cycle (GntValid = 0, Busy = 1) between each.
- All 15 bits requested, Release every grant -> grants in order bit0, 1, …, 14, 0; GntAddr sequence 1, 2, …, 14, 0, 1.
- Owner bit3 drops ReqIn[3] without asserting Release -> GAP on the next edge, pointer = 3; pending bit2 and bit5 -> bit5 is granted next (GntAddr 6).
- Release asserted in IDLE, and ReqIn changes on other bits during GRANT -> no state change, GntOut stays stable.
- With ARB_TIMEOUT_EN and HOLD_MAX = 4, owner never releases -> forced exit after 4 GRANT cycles, TimeoutPulse high for 1 cycle, next requester granted after the gap.

Source files
------------

// File: rtl/rr_addr_arbiter.sv
// Round-robin arbiter: 15 requesters share one addressed resource, grant held until release or drop.
// Optional ARB_TIMEOUT_EN bounds each grant to HOLD_MAX cycles and adds TimeoutPulse.
module rr_addr_arbiter #(
  parameter int HOLD_MAX = 255,
  parameter int PTR_INIT = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [14:0] ReqIn,
  input  logic        Release,
  output logic [14:0] GntOut,
  output logic [3:0]  GntAddr,
  output logic        GntValid,
`ifdef ARB_TIMEOUT_EN
  output logic        TimeoutPulse,
`endif
  output logic        Busy
);

  // state | meaning
  // IDLE  | no owner, arbitrate on any request
  // GRANT | owner holds the resource until release/drop
  // GAP   | one dead cycle between owners
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t      state;
  logic [3:0]  ptr;
  logic [3:0]  owner;
  logic        win_found;
  logic [3:0]  win_idx;
  logic [4:0]  sum;
  logic        drop;
  logic        grant_exit;

  function automatic logic [3:0] enc(input logic [3:0] k);
    return (k == 4'd14) ? 4'd0 : k + 4'd1;
  endfunction

  // Search starts after the pointer and visits the pointer itself last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    sum       = 5'd0;
    for (int i = 1; i <= 15; i++) begin
      sum = {1'b0, ptr} + 5'(i);
      if (sum >= 5'd15) sum = sum - 5'd15;
      if (!win_found && ReqIn[sum[3:0]]) begin
        win_found = 1'b1;
        win_idx   = sum[3:0];
      end
    end
  end

  assign drop = ~ReqIn[owner];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  logic       tmo_hit;
  assign tmo_hit    = (hold_cnt == 8'(HOLD_MAX - 1));
  assign grant_exit = Release | drop | tmo_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt     <= 8'd0;
      TimeoutPulse <= 1'b0;
    end else begin
      TimeoutPulse <= 1'b0;
      if (state == IDLE) begin
        hold_cnt <= 8'd0;
      end else if (state == GRANT) begin
        if (grant_exit) TimeoutPulse <= tmo_hit & ~Release & ~drop;
        else            hold_cnt     <= hold_cnt + 8'd1;
      end
    end
  end
`else
  assign grant_exit = Release | drop;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 4'(PTR_INIT);
      owner    <= 4'd0;
      GntOut   <= 15'd0;
      GntAddr  <= 4'd0;
      GntValid <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state    <= GRANT;
            owner    <= win_idx;
            GntOut   <= 15'd1 << win_idx;
            GntAddr  <= enc(win_idx);
            GntValid <= 1'b1;
            Busy     <= 1'b1;
          end
        end
        GRANT: begin
          if (grant_exit) begin
            state    <= GAP;
            ptr      <= owner;
            GntOut   <= 15'd0;
            GntAddr  <= 4'd0;
            GntValid <= 1'b0;
          end
        end
        GAP: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          GntOut   <= 15'd0;
          GntAddr  <= 4'd0;
          GntValid <= 1'b0;
          Busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_addr_arbiter.sv
// Directed bench for rr_addr_arbiter; define ARB_TIMEOUT_EN to also cover the hold timeout.
module tb_rr_addr_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] ReqIn;
  logic        Release;
  logic [14:0] GntOut;
  logic [3:0]  GntAddr;
  logic        GntValid;
  logic        Busy;
`ifdef ARB_TIMEOUT_EN
  logic        TimeoutPulse;
`endif

  int n_chk = 0;
  int n_fail = 0;

  rr_addr_arbiter #(.HOLD_MAX(4), .PTR_INIT(14)) dut (
    .clk(clk), .rst_n(rst_n), .ReqIn(ReqIn), .Release(Release),
    .GntOut(GntOut), .GntAddr(GntAddr), .GntValid(GntValid),
`ifdef ARB_TIMEOUT_EN
    .TimeoutPulse(TimeoutPulse),
`endif
    .Busy(Busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [14:0] g, input logic [3:0] a,
                         input logic v, input logic b);
    chk({tag, ".gnt"},   32'(GntOut),   32'(g));
    chk({tag, ".addr"},  32'(GntAddr),  32'(a));
    chk({tag, ".valid"}, 32'(GntValid), 32'(v));
    chk({tag, ".busy"},  32'(Busy),     32'(b));
  endtask

  // Expect a grant to bit k (address a) at the next edge, then release it and walk through GAP to IDLE.
  task automatic grant_release(input int k, input logic [3:0] a);
    step();
    chk_out($sformatf("grant%0d", k), 15'd1 << k, a, 1'b1, 1'b1);
    Release = 1'b1;
    step();
    Release = 1'b0;
    chk_out($sformatf("gap%0d", k), 15'd0, 4'd0, 1'b0, 1'b1);
    step();
    chk_out($sformatf("idle%0d", k), 15'd0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; ReqIn = 15'd0; Release = 1'b0;
    #12;
    chk_out("reset", 15'd0, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();

    // First grant latency, then asynchronous reset mid-grant.
    ReqIn = 15'h0001;
    step();
    chk_out("first", 15'h0001, 4'd1, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 15'd0, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    ReqIn = 15'd0;
    step();

    // Two requesters alternate: bit0, bit14, bit0.
    ReqIn = 15'h4001;
    grant_release(0, 4'd1);
    grant_release(14, 4'd0);
    grant_release(0, 4'd1);

    // All requesters: full rotation from bit0 back to bit0.
    ReqIn = 15'd0;
    step();
    do_reset();
    ReqIn = 15'h7fff;
    for (int k = 0; k < 15; k++) grant_release(k, (k == 14) ? 4'd0 : 4'(k + 1));
    grant_release(0, 4'd1);

    // Owner bit3 abandons; pointer moves to 3 so bit5 beats bit2.
    ReqIn = 15'h0008;
    step();
    chk_out("own3", 15'h0008, 4'd4, 1'b1, 1'b1);
    ReqIn = 15'h0024;
    step();
    chk_out("drop3_gap", 15'd0, 4'd0, 1'b0, 1'b1);
    step();
    chk_out("drop3_idle", 15'd0, 4'd0, 1'b0, 1'b0);
    step();
    chk_out("after_drop", 15'h0020, 4'd6, 1'b1, 1'b1);
    ReqIn = 15'h0020;
    Release = 1'b1;
    step();
    Release = 1'b0;
    ReqIn = 15'd0;
    step();

    // Release in IDLE is ignored; other bits do not preempt the owner.
    Release = 1'b1;
    step();
    chk_out("rel_idle", 15'd0, 4'd0, 1'b0, 1'b0);
    Release = 1'b0;
    ReqIn = 15'h0080;
    step();
    chk_out("own7", 15'h0080, 4'd8, 1'b1, 1'b1);
    ReqIn = 15'h0182;
    step();
    step();
    chk_out("no_preempt", 15'h0080, 4'd8, 1'b1, 1'b1);
    step();
    step();
    chk_out("hold_long", 15'h0080, 4'd8, 1'b1, 1'b1);
    ReqIn = 15'h0000;
    step();
    step();

    // Single requester is re-granted after the gap (pointer at 7).
    ReqIn = 15'h0080;
    grant_release(7, 4'd8);

`ifdef ARB_TIMEOUT_EN
    // HOLD_MAX=4: owner bit9 never releases, forced out after 4 GRANT cycles.
    ReqIn = 15'h0600;
    step();
    chk_out("tmo_own9", 15'h0200, 4'd10, 1'b1, 1'b1);
    chk("tmo_pulse_lo0", 32'(TimeoutPulse), 32'd0);
    for (int c = 0; c < 3; c++) step();
    chk_out("tmo_hold", 15'h0200, 4'd10, 1'b1, 1'b1);
    step();
    chk_out("tmo_gap", 15'd0, 4'd0, 1'b0, 1'b1);
    chk("tmo_pulse_hi", 32'(TimeoutPulse), 32'd1);
    step();
    chk("tmo_pulse_lo1", 32'(TimeoutPulse), 32'd0);
    step();
    chk_out("tmo_next", 15'h0400, 4'd11, 1'b1, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
